// File: rtl/dedup.sv
// dedup -- duplicate-suppression decision for the gesture output path.
//
// The block compares the current top-K letter candidates against the
// previous window's top-K. It raises o_next for one clock when the two sets
// share fewer than MATCH_TH symbols, so the commit logic only advances on a
// genuinely new gesture.
//
// Each request runs through four states, one edge apart:
//   IDLE -> CMP -> DEC -> OUT -> IDLE
// A request is accepted only in IDLE. A request seen in any other state is
// dropped, not queued.
//
// Ports
//   i_clk        : clock, rising-edge active
//   i_rst_n      : asynchronous active-low reset
//   i_next       : request pulse; i_tops / i_prev_tops are valid on this cycle
//   i_tops       : current candidates [0:K-1], index 0 is the most likely
//   i_prev_tops  : previous window's candidates [0:K-1]
//   o_next       : registered one-cycle pulse, "new symbol, advance"
module dedup #(
    parameter int SYM_W    = 5,
    parameter int K        = 3,
    parameter int MATCH_TH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_next,
    input  logic [SYM_W-1:0] i_tops      [0:K-1],
    input  logic [SYM_W-1:0] i_prev_tops [0:K-1],
    output logic             o_next
);

    localparam int CNT_W = $clog2(K + 1);
    localparam logic [CNT_W-1:0] MATCH_TH_C = CNT_W'(MATCH_TH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DEC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Counts the set bits of the per-position hit vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [K-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < K; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SYM_W-1:0] tops_r [0:K-1];
    logic [SYM_W-1:0] prev_r [0:K-1];
    logic [K-1:0]     hit_r;
    logic [K-1:0]     hit_s;
    logic [CNT_W-1:0] overlap_s;
    logic             new_s;
    logic             new_flag_r;
    logic             o_next_r;
    logic             capture_s;

    assign capture_s = (state_r == ST_IDLE) && i_next;

    // Next-state logic: one edge per state. Only IDLE looks at i_next.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_next) begin
                    state_nxt_s = ST_CMP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMP:  state_nxt_s = ST_DEC;
            ST_DEC:  state_nxt_s = ST_OUT;
            ST_OUT:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Set-membership test. Each current position counts at most once, so a
    // repeated symbol in the current set adds one hit per copy that matches.
    always_comb begin
        hit_s = {K{1'b0}};
        for (int j = 0; j < K; j++) begin
            for (int k = 0; k < K; k++) begin
                if (tops_r[j] == prev_r[k]) begin
                    hit_s[j] = 1'b1;
                end else begin
                    hit_s[j] = hit_s[j];
                end
            end
        end
    end

    // Overlap count and the "sufficiently different" decision.
    always_comb begin
        overlap_s = popcount(hit_r);
        new_s     = (overlap_s < MATCH_TH_C);
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture both candidate sets on the accepting edge. They are held
    // afterwards, so the inputs may change freely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < K; i++) begin
                tops_r[i] <= {SYM_W{1'b0}};
                prev_r[i] <= {SYM_W{1'b0}};
            end
        end else if (capture_s) begin
            for (int i = 0; i < K; i++) begin
                tops_r[i] <= i_tops[i];
                prev_r[i] <= i_prev_tops[i];
            end
        end else begin
            for (int i = 0; i < K; i++) begin
                tops_r[i] <= tops_r[i];
                prev_r[i] <= prev_r[i];
            end
        end
    end

    // Pipeline registers: the hit vector is loaded in CMP. The decision and
    // the output pulse are loaded together in DEC, so o_next is high exactly
    // while the FSM sits in OUT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_r      <= {K{1'b0}};
            new_flag_r <= 1'b0;
            o_next_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CMP: begin
                    hit_r    <= hit_s;
                    o_next_r <= 1'b0;
                end
                ST_DEC: begin
                    new_flag_r <= new_s;
                    o_next_r   <= new_s;
                end
                default: begin
                    o_next_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_next = o_next_r;

endmodule

// File: tb/tb_dedup.sv
// tb_dedup -- directed scoreboard bench for dedup.
//
// The stimulus side pushes {expected o_next, cycle due} when it issues a
// request. The monitor samples o_next on every falling edge. When the head
// entry is due, the monitor compares against it. On every other cycle,
// o_next must be low.
module tb_dedup;

    localparam int SYM_W = 5;
    localparam int K     = 3;

    logic             clk;
    logic             rst_n;
    logic             i_next;
    logic [SYM_W-1:0] i_tops      [0:K-1];
    logic [SYM_W-1:0] i_prev_tops [0:K-1];
    logic             o_next;

    typedef struct {
        logic exp;
        int   due;
        int   id;
    } sb_t;

    sb_t sb_q[$];
    int  cyc;
    int  n_vec;
    int  n_miscmp;
    int  vec_id;

    dedup #(.SYM_W(SYM_W), .K(K), .MATCH_TH(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_next      (i_next),
        .i_tops      (i_tops),
        .i_prev_tops (i_prev_tops),
        .o_next      (o_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count, stepped on each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the due entry, otherwise require o_next low.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            n_vec = n_vec + 1;
            if (o_next !== sb_q[0].exp) begin
                n_miscmp = n_miscmp + 1;
                $display("FAIL vec%0d o_next at cycle %0d: got %b, expected %b",
                         sb_q[0].id, cyc, o_next, sb_q[0].exp);
            end
            void'(sb_q.pop_front());
        end else if (o_next !== 1'b0) begin
            n_miscmp = n_miscmp + 1;
            $display("FAIL stray_pulse at cycle %0d: got %b, expected 0", cyc, o_next);
        end
    end

    task automatic drive_sets(input logic [SYM_W-1:0] t0, t1, t2, p0, p1, p2);
        i_tops[0]      = t0; i_tops[1]      = t1; i_tops[2]      = t2;
        i_prev_tops[0] = p0; i_prev_tops[1] = p1; i_prev_tops[2] = p2;
    endtask

    // Issue one request. The caller is 1 time unit past a rising edge.
    // mode 0 = plain pulse, 1 = i_next held through CMP and DEC,
    // 2 = reset asserted while in DEC (no pulse expected).
    // On return, the FSM is back in IDLE and time is again just past an edge.
    task automatic request(input logic [SYM_W-1:0] t0, t1, t2, p0, p1, p2,
                           input logic exp, input int mode);
        sb_t e;
        vec_id = vec_id + 1;
        e.exp  = (mode == 2) ? 1'b0 : exp;
        e.due  = cyc + 3;
        e.id   = vec_id;
        sb_q.push_back(e);
        drive_sets(t0, t1, t2, p0, p1, p2);
        i_next = 1'b1;
        @(posedge clk); #1;
        // Captured. Scramble the inputs so that a missing capture would show.
        drive_sets(p0, p1, p2, p0, p1, p2);
        if (mode == 1) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            i_next = 1'b0;
            @(posedge clk); #1;
        end else if (mode == 2) begin
            i_next = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b1;
        end else begin
            i_next = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        sb_t e;
        cyc      = 0;
        n_vec    = 0;
        n_miscmp = 0;
        vec_id   = 0;
        rst_n    = 1'b0;
        i_next   = 1'b0;
        drive_sets(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Reset held while i_next toggles: o_next must stay low.
        drive_sets(5'd4, 5'd5, 5'd6, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            i_next = ~i_next;
            vec_id = vec_id + 1;
            e.exp = 1'b0; e.due = cyc; e.id = vec_id;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        i_next = 1'b0;
        // Quiet cycles after release: no transaction may have started.
        repeat (5) begin
            @(posedge clk); #1;
        end

        request(5'd0,  5'd3,  5'd6,  5'd0,  5'd3,  5'd5,  1'b0, 0); // overlap 2
        request(5'd1,  5'd2,  5'd3,  5'd1,  5'd2,  5'd3,  1'b0, 0); // overlap 3
        request(5'd0,  5'd26, 5'd4,  5'd26, 5'd0,  5'd4,  1'b0, 0); // reordered, blank
        request(5'd4,  5'd5,  5'd6,  5'd1,  5'd4,  5'd7,  1'b1, 0); // overlap 1
        request(5'd8,  5'd9,  5'd10, 5'd0,  5'd1,  5'd2,  1'b1, 1); // held i_next
        request(5'd5,  5'd5,  5'd5,  5'd5,  5'd1,  5'd2,  1'b0, 0); // dup tops, 3
        request(5'd4,  5'd5,  5'd6,  5'd1,  5'd4,  5'd7,  1'b1, 2); // reset in DEC
        request(5'd20, 5'd21, 5'd22, 5'd20, 5'd1,  5'd2,  1'b1, 0); // right after release
        request(5'd26, 5'd26, 5'd26, 5'd0,  5'd1,  5'd2,  1'b1, 0); // overlap 0
        request(5'd7,  5'd8,  5'd9,  5'd9,  5'd8,  5'd0,  1'b0, 0); // overlap 2
        request(5'd26, 5'd3,  5'd3,  5'd3,  5'd11, 5'd12, 1'b0, 0); // dup 3s -> 2

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            n_miscmp = n_miscmp + 1;
            $display("FAIL drain: got %0d entries pending, expected 0", sb_q.size());
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
